modbus_input_snapshot: RTL
==========================

# modbus_input_snapshot

Coherent source for the slave's four function-04 input registers. It sits directly upstream of `modbus_rtu_slave_top` and drives its `read_04_01`..`read_04_04` inputs from live application data. New data is staged in a shadow bank and copied to the outputs only while the RS-485 bus is quiet, so a master never reads a torn mix of old and new words within one transaction.

## Interface
Parameters:
- `CLK_FREQ`, default 50000000: system clock in Hz.
- `BAUD_RATE`, default 115200: RS-485 baud rate.
- `TIMEOUT_CHARS`, default 32: rx-idle window, in 11-bit character times, that ends an ACTIVE period.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `src_01`..`src_04` in 16 each: live application values.
- `src_valid` in 1: single-cycle strobe; all four `src_*` are valid this cycle.
- `rs485_rx` in 1: raw bus receive line, monitored only; asynchronous.
- `response_done` in 1: single-cycle pulse from the slave core when its reply has finished.
- `read_04_01`..`read_04_04` out 16 each: committed values to the slave core.
- `pending` out 1: shadow bank holds data not yet committed.
- `bus_active` out 1: state is ACTIVE.
- `commit_cnt` out 16: number of commits; wraps.
- `ovr_cnt` out 8: captures that overwrote uncommitted data; saturates at 255.

## Operation
- `rs485_rx` passes through a 2-FF synchroniser, reset to 1. A falling edge is a synchronised 1→0 transition.
- Capture: when `src_valid` is high, `shadow[1..4] <= src_*` and `pending <= 1`. If `pending` was already 1 and no commit occurs in the same cycle, `ovr_cnt` increments, saturating.
- FSM states:
  - QUIET, the reset state. A falling edge moves to ACTIVE and clears the idle counter.
  - ACTIVE. Any cycle with synchronised rx = 0 clears the idle counter; otherwise the counter increments.
  - ACTIVE exits to QUIET on `response_done`, or when the idle counter reaches TIMEOUT_CYC - 1. The timeout covers frames addressed to other nodes.
- TIMEOUT_CYC = TIMEOUT_CHARS × 11 × (CLK_FREQ / BAUD_RATE), using integer division. The defaults give 32 × 11 × 434 = 152768. The counter width is $clog2(TIMEOUT_CYC + 1).
- Commit condition: state is QUIET, `pending` = 1, and there is no falling edge this cycle.
- Commit action: outputs take the shadow values as registered before this cycle's edge. `pending` clears, and `commit_cnt` increments.
- Capture and commit in the same cycle: the commit uses the old shadow, the new data lands in the shadow, and `pending` stays 1. The new data commits on the next eligible cycle. `ovr_cnt` does not increment.
- A falling edge in QUIET has priority over a commit; the outputs hold.
- `response_done` while in QUIET is ignored.

## Timing
- Reset values: all `read_04_*` = 16'h0000, `pending` = 0, `bus_active` = 0, `commit_cnt` = 0, `ovr_cnt` = 0. Shadow = 0, state QUIET, idle counter = 0.
- Reset asserted mid-ACTIVE returns to QUIET next cycle and discards pending data.
- Latency from `src_valid` in QUIET to new `read_04_*`: 2 cycles. The capture is at edge N+1 and the commit at edge N+2.
- Raw rx fall to `bus_active` = 1: 3 edges (2 for the synchroniser, 1 for the FSM).
- `response_done` at cycle N: QUIET at edge N+1, earliest commit at edge N+2.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `SNAPSHOT_STATS_EN` defined: `commit_cnt` and `ovr_cnt` are implemented as described above.
- `SNAPSHOT_STATS_EN` undefined: both counters are removed and their ports are tied to 0. The ports remain present. All other behaviour is identical.

## Test plan
- Reset, rx held high, `src_valid` with `src_01..04` = 1111/2222/3333/4444 → `read_04_*` show these values 2 cycles later; `pending` returns to 0; `commit_cnt` = 1.
- Drive rx low, then `src_valid` with AAAA.. → outputs hold 1111..; `pending` = 1. Pulse `response_done` → AAAA.. appears 2 cycles after the pulse.
- rx toggles for one frame, no `response_done` → state returns to QUIET exactly 152768 cycles after the last rx-low sample, and the pending data commits on the following cycle.
- Three `src_valid` strobes with values B, C, D during ACTIVE → `ovr_cnt` = 2; after exit the outputs show D only.
- `src_valid` in the same cycle as a commit → the old shadow commits first, and the new value commits 1 cycle later with `pending` staying 1 in between. Also: falling edge in the same cycle as an eligible commit → no commit, state ACTIVE.
- With the macro undefined, repeat the ovr_cnt scenario (three strobes B, C, D during ACTIVE) → `commit_cnt` = `ovr_cnt` = 0 and the `read_04_*` behaviour is unchanged. Separately, assert `rst_n` mid-ACTIVE with `pending` = 1 → all outputs return to 0 next cycle.

Source files
------------

// File: rtl/modbus_input_snapshot.sv
// Shadow-buffered function-04 input registers, committed only while RS-485 is quiet.
// Optional SNAPSHOT_STATS_EN keeps the commit and overrun counters.
module modbus_input_snapshot #(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_CHARS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] src_01,
  input  logic [15:0] src_02,
  input  logic [15:0] src_03,
  input  logic [15:0] src_04,
  input  logic        src_valid,
  input  logic        rs485_rx,
  input  logic        response_done,
  output logic [15:0] read_04_01,
  output logic [15:0] read_04_02,
  output logic [15:0] read_04_03,
  output logic [15:0] read_04_04,
  output logic        pending,
  output logic        bus_active,
  output logic [15:0] commit_cnt,
  output logic [7:0]  ovr_cnt
);

  localparam int TIMEOUT_CYC = TIMEOUT_CHARS * 11 * (CLK_FREQ / BAUD_RATE);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    QUIET  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] idle_cnt, idle_nxt;
  logic          rx_s1, rx_s2, rx_d;
  logic          rx_fall;
  logic          commit;
  logic [15:0]   sh_01, sh_02, sh_03, sh_04;

  // rx_d only feeds edge detection; rx_s2 is the synchronised level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rs485_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall    = rx_d & ~rx_s2;
  assign commit     = (state == QUIET) & pending & ~rx_fall;
  assign bus_active = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= QUIET;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    unique case (state)
      QUIET: begin
        if (rx_fall) begin
          state_nxt = ACTIVE;
          idle_nxt  = '0;
        end
      end
      ACTIVE: begin
        if (response_done) begin
          state_nxt = QUIET;
        end else if (!rx_s2) begin
          idle_nxt = '0;
        end else if (idle_cnt == CNT_LAST) begin
          state_nxt = QUIET;
        end else begin
          idle_nxt = idle_cnt + CW'(1);
        end
      end
    endcase
  end

  // A commit reads the shadow as it was before this edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_01      <= '0;
      sh_02      <= '0;
      sh_03      <= '0;
      sh_04      <= '0;
      read_04_01 <= '0;
      read_04_02 <= '0;
      read_04_03 <= '0;
      read_04_04 <= '0;
      pending    <= 1'b0;
    end else begin
      if (src_valid) begin
        sh_01 <= src_01;
        sh_02 <= src_02;
        sh_03 <= src_03;
        sh_04 <= src_04;
      end
      if (commit) begin
        read_04_01 <= sh_01;
        read_04_02 <= sh_02;
        read_04_03 <= sh_03;
        read_04_04 <= sh_04;
      end
      if (src_valid) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SNAPSHOT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_cnt <= '0;
      ovr_cnt    <= '0;
    end else begin
      if (commit) begin
        commit_cnt <= commit_cnt + 16'd1;
      end
      if (src_valid && pending && !commit && ovr_cnt != 8'hFF) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end
  end
`else
  assign commit_cnt = '0;
  assign ovr_cnt    = '0;
`endif

endmodule
